neopix_chain_tx: RTL

Parametrised successor to the single-format WS2812 driver. It serialises a chain of addressable LEDs, WS2812B RGB or SK6812 RGBW, onto one data line, and every timing value is derived from nanosecond parameters. Pixel data is fetched from an upstream frame buffer through a request/address/data handshake. The next LED is prefetched, so the bit stream has no inter-LED gap. Optional auto-repeat refreshes the chain without software restarts.

---
 rtl/neopix_chain_tx_pkg.sv | 33 +++
 rtl/neopix_bit_gen.sv | 41 ++++
 rtl/neopix_chain_tx.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/neopix_chain_tx_pkg.sv
// neopix_chain_tx_pkg: shared types and helpers for the LED chain driver.
// FSM state encoding, wire-order byte lanes and ns-to-cycle conversion.
package neopix_chain_tx_pkg;

  typedef enum logic [2:0] {
    S_GAP,
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_BIT
  } state_t;

  // Byte lanes in wire order, first lane in the pixel MSBs.
  typedef enum int {
    LANE_G = 0,
    LANE_R = 1,
    LANE_B = 2,
    LANE_W = 3
  } lane_e;

  // Truncating conversion; 64-bit so long gaps at high clocks fit.
  function automatic int ns2cyc(input longint clk_hz,
                                input longint ns);
    return int'((clk_hz / 64'd1000) * ns / 64'd1000000);
  endfunction

  // Legal formats end on the B lane (RGB) or the W lane (RGBW).
  function automatic bit bpl_ok(input int bpl);
    return (bpl - 1 == int'(LANE_B)) ||
           (bpl - 1 == int'(LANE_W));
  endfunction

endpackage

// File: rtl/neopix_bit_gen.sv
// neopix_bit_gen: per-bit cycle counter and pulse shaper.
// i_en/i_bit in; o_do line level, o_bit_last and o_pf_slot strobes.
module neopix_bit_gen #(
  parameter int CYC_BIT = 62,
  parameter int CYC_T0H = 20,
  parameter int CYC_T1H = 40
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_bit,
  output logic o_do,
  output logic o_bit_last,
  output logic o_pf_slot
);

  localparam int CW = $clog2(CYC_BIT);
  localparam logic [CW-1:0] LAST = CW'(CYC_BIT - 1);
  localparam logic [CW-1:0] PF   = CW'(CYC_BIT - 3);
  localparam logic [CW-1:0] T0H  = CW'(CYC_T0H);
  localparam logic [CW-1:0] T1H  = CW'(CYC_T1H);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_thr;

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_thr      = i_bit ? T1H : T0H;
  assign o_do       = i_en && (r_cnt < w_thr);
  assign o_bit_last = i_en && (r_cnt == LAST);
  assign o_pf_slot  = i_en && (r_cnt == PF);

endmodule

// File: rtl/neopix_chain_tx.sv
// neopix_chain_tx: serialises a WS2812B/SK6812 chain from a frame buffer.
// Ports: clk_i/reset_i, start_i/repeat_i/led_count_i control, busy_o/done_o
// status, data_request_o/address_o/pixel_i fetch, do_o serial line.
module neopix_chain_tx
  import neopix_chain_tx_pkg::*;
#(
  parameter int NUM_LEDS      = 8,
  parameter int SYSTEM_CLOCK  = 50_000_000,
  parameter int BYTES_PER_LED = 3,
  parameter int BIT_NS        = 1250,
  parameter int T0H_NS        = 400,
  parameter int T1H_NS        = 800,
  parameter int RESET_NS      = 80_000
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic                            repeat_i,
  input  logic [$clog2(NUM_LEDS+1)-1:0]   led_count_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            data_request_o,
  output logic [$clog2(NUM_LEDS)-1:0]     address_o,
  input  logic [8*BYTES_PER_LED-1:0]      pixel_i,
  output logic                            do_o
);

  localparam int CYC_BIT = ns2cyc(SYSTEM_CLOCK, BIT_NS);
  localparam int CYC_T0H = ns2cyc(SYSTEM_CLOCK, T0H_NS);
  localparam int CYC_T1H = ns2cyc(SYSTEM_CLOCK, T1H_NS);
  localparam int CYC_RST = ns2cyc(SYSTEM_CLOCK, RESET_NS);

  localparam int NB = 8 * BYTES_PER_LED;
  localparam int NW = $clog2(NUM_LEDS + 1);
  localparam int AW = $clog2(NUM_LEDS);
  localparam int BW = $clog2(NB);
  localparam int GW = $clog2(CYC_RST + 1);

  localparam logic [NW-1:0] NMAX  = NW'(NUM_LEDS);
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [GW-1:0] GLAST = GW'(CYC_RST - 1);

  if (!bpl_ok(BYTES_PER_LED)) begin : g_bad_bpl
    $error("BYTES_PER_LED must be 3 or 4");
  end
  if (CYC_BIT < 4) begin : g_bad_bit
    $error("bit period too short for the prefetch slot");
  end
  if (!(CYC_T0H < CYC_T1H && CYC_T1H < CYC_BIT)) begin : g_bad_hi
    $error("need CYC_T0H < CYC_T1H < CYC_BIT");
  end
  if (CYC_RST < 1) begin : g_bad_rst
    $error("reset gap must be at least one cycle");
  end
  if (NUM_LEDS < 2) begin : g_bad_num
    $error("NUM_LEDS must be at least 2");
  end

  state_t        r_state;
  state_t        w_next;
  logic          r_s1;
  logic          r_s2;
  logic          r_pend;
  logic [NW-1:0] r_n;
  logic [AW-1:0] r_led;
  logic [AW-1:0] r_addr;
  logic [BW-1:0] r_bit;
  logic [NB-1:0] r_shift;
  logic [NB-1:0] r_shadow;
  logic          r_fetch;
  logic [GW-1:0] r_gap;

  logic          w_edge;
  logic [NW-1:0] w_n_in;
  logic [NW-1:0] w_led_nx;
  logic          w_more;
  logic          w_last_bit;
  logic          w_in_bit;
  logic          w_bit_end;
  logic          w_pf_slot;
  logic          w_pf;
  logic          w_done;
  logic          w_req;
  logic [AW-1:0] w_addr;

  assign w_edge     = r_s1 & ~r_s2;
  assign w_n_in     = (led_count_i > NMAX) ? NMAX : led_count_i;
  assign w_led_nx   = NW'(r_led) + NW'(1);
  assign w_more     = w_led_nx < r_n;
  assign w_last_bit = r_bit == BLAST;
  assign w_in_bit   = r_state == S_BIT;
  // Next LED is fetched only from the final bit of the current one.
  assign w_pf       = w_pf_slot && w_last_bit && w_more;

  neopix_bit_gen #(
    .CYC_BIT (CYC_BIT),
    .CYC_T0H (CYC_T0H),
    .CYC_T1H (CYC_T1H)
  ) u_bit_gen (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_en       (w_in_bit),
    .i_bit      (r_shift[NB-1]),
    .o_do       (do_o),
    .o_bit_last (w_bit_end),
    .o_pf_slot  (w_pf_slot)
  );

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_req  = 1'b0;
    w_addr = r_addr;
    unique case (r_state)
      S_GAP: begin
        if (r_gap == GLAST) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (r_pend || repeat_i) w_next = S_REQ;
      end
      S_REQ: begin
        if (w_n_in == '0) begin
          w_done = 1'b1;
          w_next = S_GAP;
        end else begin
          w_req  = 1'b1;
          w_addr = '0;
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next = S_BIT;
      end
      S_BIT: begin
        if (w_pf) begin
          w_req  = 1'b1;
          w_addr = r_led + AW'(1);
        end
        if (w_bit_end && w_last_bit && !w_more) begin
          w_done = 1'b1;
          w_next = S_GAP;
        end
      end
      default: begin
        w_next = S_GAP;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= S_GAP;
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_pend   <= 1'b0;
      r_n      <= '0;
      r_led    <= '0;
      r_addr   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_shadow <= '0;
      r_fetch  <= 1'b0;
      r_gap    <= '0;
    end else begin
      r_state <= w_next;
      r_s1    <= start_i;
      r_s2    <= r_s1;
      // A fresh edge wins over the clear so it is never lost.
      if (w_edge) begin
        r_pend <= 1'b1;
      end else if (r_state == S_IDLE && w_next == S_REQ) begin
        r_pend <= 1'b0;
      end
      if (r_state == S_GAP && w_next == S_GAP) begin
        r_gap <= r_gap + GW'(1);
      end else begin
        r_gap <= '0;
      end
      r_addr  <= (w_next == S_GAP) ? '0 : w_addr;
      r_fetch <= w_in_bit && w_pf;
      if (r_fetch) r_shadow <= pixel_i;
      if (r_state == S_REQ) begin
        r_n   <= w_n_in;
        r_led <= '0;
      end
      if (r_state == S_LOAD) begin
        r_shift <= pixel_i;
        r_bit   <= '0;
      end else if (w_in_bit && w_bit_end) begin
        if (w_last_bit) begin
          r_bit   <= '0;
          r_shift <= r_shadow;
          r_led   <= r_led + AW'(1);
        end else begin
          r_bit   <= r_bit + BW'(1);
          r_shift <= {r_shift[NB-2:0], 1'b0};
        end
      end
    end
  end

  assign busy_o         = r_state != S_IDLE;
  assign done_o         = w_done;
  assign data_request_o = w_req;
  assign address_o      = w_addr;

endmodule
